// File: rtl/aes_key_expansion_if.sv
// ============================================================================
// Module      : aes_key_expansion_if
// Description : Bus bundle between the key-expansion block and its neighbours:
//               start/key request in, round key stream out.
//               Carries last_key when AES_KEY_EXP_LAST_KEY_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface aes_key_expansion_if #(
  parameter int N = 128,
  parameter int R = 10
);
  logic                      start;
  logic [N-1:0]              cipher_key;
  logic [N-1:0]              round_key;
  logic [$clog2(R+1)-1:0]    roundnum;
  logic                      key_valid;
  logic                      done;
  logic                      busy;
`ifdef AES_KEY_EXP_LAST_KEY_EN
  logic [N-1:0]              last_key;
`endif

  modport master (
    output start, cipher_key,
    input  round_key, roundnum, key_valid, done, busy
`ifdef AES_KEY_EXP_LAST_KEY_EN
    , input last_key
`endif
  );

  modport slave (
    input  start, cipher_key,
    output round_key, roundnum, key_valid, done, busy
`ifdef AES_KEY_EXP_LAST_KEY_EN
    , output last_key
`endif
  );
endinterface

`default_nettype wire

// File: rtl/aes_key_expansion.sv
// ============================================================================
// Module      : aes_key_expansion
// Description : Iterative AES-128 key schedule, one round key per clock
//               (rounds 0..R). Optional macro AES_KEY_EXP_LAST_KEY_EN adds a
//               last_key register holding the final round key for decryption.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module aes_key_expansion #(
  parameter int N = 128,
  parameter int R = 10
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  aes_key_expansion_if.slave   bus
);

  localparam int               RW     = $clog2(R + 1);
  localparam logic [RW-1:0]    c_last = RW'(R);

  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 of the table sits in the most significant byte.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    int idx;
    idx = 255 - int'(x);
    return c_sbox[idx*8 +: 8];
  endfunction

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_round_key, w_key_nxt;
  logic [RW-1:0]   r_roundnum, w_rnd_nxt;
  logic            r_key_valid, w_valid_nxt;
  logic            r_busy, w_busy_nxt;
  logic [7:0]      r_rcon, w_rcon_nxt;
  logic            w_done;

  logic [31:0]     w_rot;
  logic [31:0]     w_sub;
  logic [31:0]     w_t;
  logic [31:0]     w_w0, w_w1, w_w2, w_w3;
  logic [N-1:0]    w_next_key;
  logic [7:0]      w_rcon_adv;

  assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign w_sub[i*8 +: 8] = sbox(w_rot[i*8 +: 8]);
  end

  assign w_t        = w_sub ^ {r_rcon, 24'h000000};
  assign w_w0       = r_round_key[127:96] ^ w_t;
  assign w_w1       = r_round_key[95:64]  ^ w_w0;
  assign w_w2       = r_round_key[63:32]  ^ w_w1;
  assign w_w3       = r_round_key[31:0]   ^ w_w2;
  assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

  assign w_rcon_adv = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
  assign w_done     = r_key_valid && (r_roundnum == c_last);

  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_round_key;
    w_rnd_nxt   = r_roundnum;
    w_valid_nxt = r_key_valid;
    w_busy_nxt  = r_busy;
    w_rcon_nxt  = r_rcon;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_key_nxt   = bus.cipher_key;
          w_rnd_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
          w_rcon_nxt  = 8'h01;
          w_state_nxt = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (r_roundnum < c_last) begin
          w_key_nxt  = w_next_key;
          w_rnd_nxt  = r_roundnum + RW'(1);
          w_rcon_nxt = w_rcon_adv;
        end else begin
          // Final key stays visible on round_key after the stream ends.
          w_rnd_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_round_key <= '0;
      r_roundnum  <= '0;
      r_key_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_rcon      <= 8'h00;
    end else begin
      r_state     <= w_state_nxt;
      r_round_key <= w_key_nxt;
      r_roundnum  <= w_rnd_nxt;
      r_key_valid <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_rcon      <= w_rcon_nxt;
    end
  end

`ifdef AES_KEY_EXP_LAST_KEY_EN
  logic [N-1:0] r_last_key;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_key <= '0;
    end else if (w_done) begin
      r_last_key <= r_round_key;
    end
  end

  assign bus.last_key = r_last_key;
`endif

  assign bus.round_key = r_round_key;
  assign bus.roundnum  = r_roundnum;
  assign bus.key_valid = r_key_valid;
  assign bus.done      = w_done;
  assign bus.busy      = r_busy;

endmodule

`default_nettype wire
